// File: rtl/rr_decoder_arbiter.sv
// ============================================================================
// rr_decoder_arbiter
// ----------------------------------------------------------------------------
// Four-requester round-robin arbiter that shares one decoder-addressed
// resource among four clients. The winner index drives grant_addr, and a
// registered one-hot grant drives the four decoder enables.
//
// An owner keeps the grant for as long as it holds its request. Every change
// of ownership goes through one all-zero cycle (break-before-make), so two
// enables are never high together. The round-robin pointer always points just
// past the last owner.
//
// Optional feature (compile-time macro): ARB_HOLD_LIMIT_EN
//   When defined, an owner is force-released after MAX_HOLD consecutive grant
//   cycles and timeout pulses for one cycle. When undefined, there is no
//   counter logic, tenure is unbounded, and timeout is constant 0.
//
// Parameters
//   MAX_HOLD     max consecutive grant cycles per owner (1..255)
//   HOLD_W       hold counter width, 2**HOLD_W > MAX_HOLD
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-high reset
//   req[3:0]     in   request per client
//   grant[3:0]   out  registered one-hot grant, 4'b0000 when idle
//   grant_addr   out  encoded owner index, 2'b00 when idle
//   grant_valid  out  high whenever grant is non-zero (decoder enable)
//   timeout      out  one-cycle pulse on a forced release
// ============================================================================
module rr_decoder_arbiter #(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned HOLD_W   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] grant_addr,
    output logic       grant_valid,
    output logic       timeout
);

    // Parameter legality is checked once at elaboration.
    localparam bit PARAMS_OK = (MAX_HOLD >= 1) && (MAX_HOLD <= 255) &&
                               ((2 ** HOLD_W) > MAX_HOLD);

    if (!PARAMS_OK) begin : g_bad_params
        $error("rr_decoder_arbiter: illegal MAX_HOLD/HOLD_W combination");
    end

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [3:0]  grant_r;
    logic [3:0]  grant_s;
    logic [1:0]  addr_r;
    logic [1:0]  addr_s;
    logic        valid_r;
    logic        valid_s;
    logic        timeout_r;
    logic        timeout_s;
    logic [1:0]  ptr_r;
    logic [1:0]  ptr_s;
    logic        win_found_s;
    logic [1:0]  win_idx_s;
    logic        hold_expire_s;

    // Two-bit index to one-hot decoder enable.
    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        logic [3:0] oh;
        oh = 4'b0001 << idx;
        return oh;
    endfunction

    // Round-robin scan: first requester at ptr, ptr+1, ptr+2, ptr+3 (2-bit wrap).
    // Scanning from the farthest offset down lets the nearest hit win.
    always_comb begin
        logic [1:0] cand;
        win_found_s = 1'b0;
        win_idx_s   = 2'b00;
        cand        = 2'b00;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr_r + 2'(k);
            if (req[cand]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

`ifdef ARB_HOLD_LIMIT_EN
    logic [HOLD_W-1:0] hold_cnt_r;
    logic [HOLD_W-1:0] hold_cnt_s;

    // Tenure limit reached on this edge (counter started at 0 on the grant edge).
    always_comb begin
        hold_expire_s = (hold_cnt_r == HOLD_W'(MAX_HOLD - 1));
    end
`else
    // Without the hold limit a tenure never expires.
    always_comb begin
        hold_expire_s = 1'b0;
    end
`endif

    // Next-state and next-output logic for the IDLE/GRANT machine.
    always_comb begin
        state_s   = state_r;
        grant_s   = grant_r;
        addr_s    = addr_r;
        valid_s   = valid_r;
        timeout_s = 1'b0;
        ptr_s     = ptr_r;
`ifdef ARB_HOLD_LIMIT_EN
        hold_cnt_s = hold_cnt_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (win_found_s) begin
                    state_s = ST_GRANT;
                    grant_s = onehot4(win_idx_s);
                    addr_s  = win_idx_s;
                    valid_s = 1'b1;
`ifdef ARB_HOLD_LIMIT_EN
                    hold_cnt_s = {HOLD_W{1'b0}};
`endif
                end else begin
                    grant_s = 4'b0000;
                    addr_s  = 2'b00;
                    valid_s = 1'b0;
                end
            end
            ST_GRANT: begin
                // Natural release is checked first so it wins over a timeout
                // on the same edge. Either release leaves one bubble cycle.
                if (!req[addr_r]) begin
                    state_s = ST_IDLE;
                    grant_s = 4'b0000;
                    addr_s  = 2'b00;
                    valid_s = 1'b0;
                    ptr_s   = addr_r + 2'd1;
                end else if (hold_expire_s) begin
                    state_s   = ST_IDLE;
                    grant_s   = 4'b0000;
                    addr_s    = 2'b00;
                    valid_s   = 1'b0;
                    ptr_s     = addr_r + 2'd1;
                    timeout_s = 1'b1;
                end else begin
`ifdef ARB_HOLD_LIMIT_EN
                    hold_cnt_s = hold_cnt_r + {{(HOLD_W-1){1'b0}}, 1'b1};
`endif
                    state_s = ST_GRANT;
                end
            end
            default: begin
                state_s = ST_IDLE;
                grant_s = 4'b0000;
                addr_s  = 2'b00;
                valid_s = 1'b0;
                ptr_s   = 2'b00;
            end
        endcase
    end

    // State, pointer and registered outputs; reset drops any grant immediately.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            grant_r   <= 4'b0000;
            addr_r    <= 2'b00;
            valid_r   <= 1'b0;
            timeout_r <= 1'b0;
            ptr_r     <= 2'b00;
        end else begin
            state_r   <= state_s;
            grant_r   <= grant_s;
            addr_r    <= addr_s;
            valid_r   <= valid_s;
            timeout_r <= timeout_s;
            ptr_r     <= ptr_s;
        end
    end

`ifdef ARB_HOLD_LIMIT_EN
    // Consecutive grant-cycle counter for the current owner.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt_r <= {HOLD_W{1'b0}};
        end else begin
            hold_cnt_r <= hold_cnt_s;
        end
    end
`endif

    assign grant       = grant_r;
    assign grant_addr  = addr_r;
    assign grant_valid = valid_r;
    assign timeout     = timeout_r;

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
module tb_rr_decoder_arbiter;

    localparam int HOLD = 8;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] grant_addr;
    logic       grant_valid;
    logic       timeout;

    rr_decoder_arbiter #(.MAX_HOLD(HOLD), .HOLD_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .grant       (grant),
        .grant_addr  (grant_addr),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] rq;
        logic [3:0] g;
        logic       t;
        string      name;
    } vec_t;

    typedef struct {
        logic [3:0] g;
        logic [1:0] a;
        logic       v;
        logic       t;
        string      name;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic logic [1:0] enc(input logic [3:0] g);
        logic [1:0] a;
        a = 2'd0;
        if (g[1]) a = 2'd1;
        if (g[2]) a = 2'd2;
        if (g[3]) a = 2'd3;
        return a;
    endfunction

    task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] g,
                       input logic t, input string nm);
        vec_t v;
        v.rst = r; v.rq = rq; v.g = g; v.t = t; v.name = nm;
        vecs.push_back(v);
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare after the edge.
    task automatic apply(input vec_t v);
        exp_t e;
        exp_t got;
        @(negedge clk);
        reset = v.rst;
        req   = v.rq;
        e.g = v.g; e.a = enc(v.g); e.v = |v.g; e.t = v.t; e.name = v.name;
        sb.push_back(e);
        @(posedge clk);
        #1;
        n_checks++;
        if (sb.size() == 0) begin
            $display("FAIL %s: scoreboard empty", v.name);
        end else begin
            got = sb.pop_front();
            if (grant !== got.g || grant_addr !== got.a ||
                grant_valid !== got.v || timeout !== got.t) begin
                $display("FAIL %s: got grant=%b addr=%0d valid=%b timeout=%b, want grant=%b addr=%0d valid=%b timeout=%b",
                         got.name, grant, grant_addr, grant_valid, timeout,
                         got.g, got.a, got.v, got.t);
            end else begin
                n_pass++;
            end
        end
    endtask

    task automatic run_table();
        for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);
        vecs.delete();
    endtask

    initial begin
        reset = 1'b1;
        req   = 4'b0000;

        // 1: reset held with all requesting, then first grant to client 0
        add(1'b1, 4'b1111, 4'b0000, 1'b0, "reset_hold0");
        add(1'b1, 4'b1111, 4'b0000, 1'b0, "reset_hold1");
        add(1'b0, 4'b1111, 4'b0001, 1'b0, "reset_release");
        add(1'b0, 4'b0000, 4'b0000, 1'b0, "c0_drop");          // ptr -> 1
        // 2: single client 2 for five cycles, then client 3 after the bubble
        add(1'b0, 4'b0100, 4'b0100, 1'b0, "single_c2_0");
        add(1'b0, 4'b0100, 4'b0100, 1'b0, "single_c2_1");
        add(1'b0, 4'b0100, 4'b0100, 1'b0, "single_c2_2");
        add(1'b0, 4'b0100, 4'b0100, 1'b0, "single_c2_3");
        add(1'b0, 4'b0100, 4'b0100, 1'b0, "single_c2_4");
        add(1'b0, 4'b1000, 4'b0000, 1'b0, "c2_drop_bubble");   // ptr -> 3
        add(1'b0, 4'b1000, 4'b1000, 1'b0, "c3_after_bubble");
        add(1'b0, 4'b0000, 4'b0000, 1'b0, "c3_drop");          // ptr -> 0
        // 3: rotation with all four requesting
        add(1'b0, 4'b1111, 4'b0001, 1'b0, "rot_c0_a");
        add(1'b0, 4'b1111, 4'b0001, 1'b0, "rot_c0_b");
        add(1'b0, 4'b1110, 4'b0000, 1'b0, "rot_bub0");
        add(1'b0, 4'b1111, 4'b0010, 1'b0, "rot_c1_a");
        add(1'b0, 4'b1111, 4'b0010, 1'b0, "rot_c1_b");
        add(1'b0, 4'b1101, 4'b0000, 1'b0, "rot_bub1");
        add(1'b0, 4'b1111, 4'b0100, 1'b0, "rot_c2_a");
        add(1'b0, 4'b1111, 4'b0100, 1'b0, "rot_c2_b");
        add(1'b0, 4'b1011, 4'b0000, 1'b0, "rot_bub2");
        add(1'b0, 4'b1111, 4'b1000, 1'b0, "rot_c3_a");
        add(1'b0, 4'b1111, 4'b1000, 1'b0, "rot_c3_b");
        add(1'b0, 4'b0111, 4'b0000, 1'b0, "rot_bub3");
        add(1'b0, 4'b1111, 4'b0001, 1'b0, "rot_c0_again");
        add(1'b0, 4'b0000, 4'b0000, 1'b0, "rot_end");          // ptr -> 1
        // 4: skip and wrap from ptr=3
        add(1'b0, 4'b0100, 4'b0100, 1'b0, "wrap_c2");
        add(1'b0, 4'b0011, 4'b0000, 1'b0, "wrap_c2_drop");     // ptr -> 3
        add(1'b0, 4'b0011, 4'b0001, 1'b0, "wrap_to_c0");
        add(1'b0, 4'b0011, 4'b0001, 1'b0, "wrap_c0_hold");
        add(1'b0, 4'b0010, 4'b0000, 1'b0, "wrap_c0_drop");     // ptr -> 1
        add(1'b0, 4'b0010, 4'b0010, 1'b0, "wrap_c1");
        // 5: mid-grant reset drops the grant at that edge and clears ptr
        add(1'b1, 4'b0010, 4'b0000, 1'b0, "midreset_drop");
        add(1'b0, 4'b0010, 4'b0010, 1'b0, "midreset_c1_again");
        add(1'b0, 4'b0000, 4'b0000, 1'b0, "midreset_c1_drop"); // ptr -> 2
        add(1'b1, 4'b0000, 4'b0000, 1'b0, "reset_ptr");
        add(1'b0, 4'b1001, 4'b0001, 1'b0, "ptr_zero_after_reset");
        add(1'b0, 4'b0000, 4'b0000, 1'b0, "c0_drop2");
        add(1'b1, 4'b0000, 4'b0000, 1'b0, "reset_before_hold"); // ptr -> 0
        run_table();

        // 6: hold-limit behaviour with a persistent two-client request
`ifdef ARB_HOLD_LIMIT_EN
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < HOLD; c++)
                add(1'b0, 4'b0011, (r == 0) ? 4'b0001 : 4'b0010, 1'b0, "hold_tenure");
            add(1'b0, 4'b0011, 4'b0000, 1'b1, "hold_timeout");
        end
        add(1'b0, 4'b0011, 4'b0001, 1'b0, "hold_c0_recompete");
        add(1'b0, 4'b0000, 4'b0000, 1'b0, "hold_c0_drop");     // ptr -> 1
        // natural release on the expiring edge suppresses timeout
        add(1'b0, 4'b0001, 4'b0001, 1'b0, "prio_grant");
        for (int c = 1; c < HOLD; c++)
            add(1'b0, 4'b0001, 4'b0001, 1'b0, "prio_hold");
        add(1'b0, 4'b0000, 4'b0000, 1'b0, "prio_natural_release");
        add(1'b0, 4'b0000, 4'b0000, 1'b0, "prio_idle");
`else
        for (int c = 0; c < 3 * HOLD; c++)
            add(1'b0, 4'b0011, 4'b0001, 1'b0, "unbounded_c0");
        add(1'b0, 4'b0010, 4'b0000, 1'b0, "unbounded_drop");
        add(1'b0, 4'b0010, 4'b0010, 1'b0, "unbounded_c1");
        add(1'b0, 4'b0000, 4'b0000, 1'b0, "unbounded_end");
`endif
        run_table();

        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
